// File: rtl/pacman_pkg.sv
// Shared definitions for the pellet map: playfield dimensions, the linear
// tile address type and the pellet_map_arbiter state encoding.
package pacman_pkg;

    localparam int unsigned TILE_COLS = 40;
    localparam int unsigned TILE_ROWS = 30;
    localparam int unsigned NUM_TILES = TILE_COLS * TILE_ROWS;

    typedef logic [10:0] tile_addr_t;

    localparam tile_addr_t LAST_TILE_ADDR = tile_addr_t'(NUM_TILES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_EAT_CHK,
        ST_DONE
    } arb_state_t;

endpackage

// File: rtl/pellet_tile_addr.sv
// Tile coordinate to linear address converter.
//   col, row  : tile coordinates (col 0..63, row 0..31 representable)
//   addr      : row*TILE_COLS + col
//   in_range  : 1 when col < TILE_COLS and row < TILE_ROWS
module pellet_tile_addr
    import pacman_pkg::*;
(
    input  logic [5:0] col,
    input  logic [4:0] row,
    output tile_addr_t addr,
    output logic       in_range
);

    assign addr     = tile_addr_t'(row) * tile_addr_t'(TILE_COLS) + tile_addr_t'(col);
    assign in_range = (col < 6'(TILE_COLS)) && (row < 5'(TILE_ROWS));

endmodule

// File: rtl/pellet_map_arbiter.sv
// Pellet bitmap owner and single-port arbiter.
//   Render port   : rd_req/rd_col/rd_row -> rd_data (1-cycle latency, always granted)
//   Eat port      : eat_req/eat_col/eat_row -> eat_done pulse + eat_hit
//   Refill        : refill_start pulse; sweeps layout_addr over the layout ROM,
//                   writing layout_bit into the map; refill_done pulse at the end
//   Status        : pellets_left (live count), map_valid (first refill finished)
// Port priority: render > refill > eat.
module pellet_map_arbiter
    import pacman_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic [5:0]  rd_col,
    input  logic [4:0]  rd_row,
    output logic        rd_data,
    input  logic        eat_req,
    input  logic [5:0]  eat_col,
    input  logic [4:0]  eat_row,
    output logic        eat_done,
    output logic        eat_hit,
    input  logic        refill_start,
    output logic [10:0] layout_addr,
    input  logic        layout_bit,
    output logic        refill_done,
    output logic [10:0] pellets_left,
    output logic        map_valid
);

    tile_addr_t rd_addr, eat_addr;
    logic       rd_in_range, eat_in_range;

    pellet_tile_addr u_rd_addr (
        .col      (rd_col),
        .row      (rd_row),
        .addr     (rd_addr),
        .in_range (rd_in_range)
    );

    pellet_tile_addr u_eat_addr (
        .col      (eat_col),
        .row      (eat_row),
        .addr     (eat_addr),
        .in_range (eat_in_range)
    );

    // Bitmap storage, single port with registered read.
    logic       mem [0:NUM_TILES-1];
    logic       ram_q;
    logic       ram_we, ram_re, ram_wd;
    tile_addr_t ram_addr;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wd;
        end else if (ram_re) begin
            ram_q <= mem[ram_addr];
        end
    end

    arb_state_t state_q, state_d;
    logic       pend_q, pend_d;
    tile_addr_t fill_addr_q, fill_addr_d;
    tile_addr_t count_q, count_d;
    logic       valid_q, valid_d;
    logic       done_q, done_d;
    logic       hit_q, hit_d;
    logic       rdone_q, rdone_d;
    logic       rd_ok_q, rd_ok_d;
    logic       chk_first_q, chk_first_d;
    logic       eat_bit;

    // The RAM output holds the eat read only in the first EAT_CHK cycle; a
    // render read may overwrite it later. Staying in EAT_CHK past that cycle
    // only happens when the bit was 1, so the bit can be reconstructed.
    assign eat_bit = chk_first_q ? ram_q : 1'b1;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q | refill_start;
        fill_addr_d = fill_addr_q;
        count_d     = count_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        hit_d       = 1'b0;
        rdone_d     = 1'b0;
        rd_ok_d     = rd_req & rd_in_range & valid_q;
        ram_we      = 1'b0;
        ram_re      = rd_req & rd_in_range;
        ram_wd      = 1'b0;
        ram_addr    = rd_addr;

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d     = ST_REFILL;
                    pend_d      = refill_start;
                    count_d     = '0;
                    fill_addr_d = '0;
                end else if (eat_req) begin
                    if (!eat_in_range) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (!rd_req) begin
                        ram_re   = 1'b1;
                        ram_addr = eat_addr;
                        state_d  = ST_EAT_CHK;
                    end
                end
            end
            ST_REFILL: begin
                if (!rd_req) begin
                    ram_we   = 1'b1;
                    ram_addr = fill_addr_q;
                    ram_wd   = layout_bit;
                    count_d  = count_q + tile_addr_t'(layout_bit);
                    if (fill_addr_q == LAST_TILE_ADDR) begin
                        state_d = ST_IDLE;
                        rdone_d = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        fill_addr_d = fill_addr_q + 11'd1;
                    end
                end
            end
            ST_EAT_CHK: begin
                if (!eat_bit) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (!rd_req) begin
                    ram_we   = 1'b1;
                    ram_addr = eat_addr;
                    ram_wd   = 1'b0;
                    count_d  = count_q - 11'd1;
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    hit_d    = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        chk_first_d = (state_q == ST_IDLE) && (state_d == ST_EAT_CHK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            fill_addr_q <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            rdone_q     <= 1'b0;
            rd_ok_q     <= 1'b0;
            chk_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            fill_addr_q <= fill_addr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
            rdone_q     <= rdone_d;
            rd_ok_q     <= rd_ok_d;
            chk_first_q <= chk_first_d;
        end
    end

    assign rd_data      = ram_q & rd_ok_q;
    assign eat_done     = done_q;
    assign eat_hit      = hit_q;
    assign refill_done  = rdone_q;
    assign pellets_left = count_q;
    assign map_valid    = valid_q;
    assign layout_addr  = fill_addr_q;

endmodule

// File: tb/tb_pellet_map_arbiter.sv
// Self-checking bench for pellet_map_arbiter: directed scenarios plus a
// randomized eat/render mix, checked against a tile-array reference model.
module tb_pellet_map_arbiter;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int TILES = 1200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_req = 1'b0;
    logic [5:0]  rd_col = '0;
    logic [4:0]  rd_row = '0;
    logic        rd_data;
    logic        eat_req = 1'b0;
    logic [5:0]  eat_col = '0;
    logic [4:0]  eat_row = '0;
    logic        eat_done, eat_hit;
    logic        refill_start = 1'b0;
    logic [10:0] layout_addr;
    logic        layout_bit;
    logic        refill_done;
    logic [10:0] pellets_left;
    logic        map_valid;

    bit layout    [TILES];
    bit model_map [TILES];
    int model_cnt;
    bit model_valid;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Layout ROM: combinational lookup.
    assign layout_bit = (layout_addr < 11'(TILES)) ? layout[layout_addr] : 1'b0;

    pellet_map_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .rd_req       (rd_req),
        .rd_col       (rd_col),
        .rd_row       (rd_row),
        .rd_data      (rd_data),
        .eat_req      (eat_req),
        .eat_col      (eat_col),
        .eat_row      (eat_row),
        .eat_done     (eat_done),
        .eat_hit      (eat_hit),
        .refill_start (refill_start),
        .layout_addr  (layout_addr),
        .layout_bit   (layout_bit),
        .refill_done  (refill_done),
        .pellets_left (pellets_left),
        .map_valid    (map_valid)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_read(input logic [5:0] c, input logic [4:0] r);
        if (!model_valid || int'(c) >= COLS || int'(r) >= ROWS) return 1'b0;
        return model_map[int'(r) * COLS + int'(c)];
    endfunction

    // One clock; a render request presented in this cycle is checked on the
    // next, against the model as it stood when the request was made.
    task automatic step();
        bit was_rd, exp_rd;
        was_rd = rd_req;
        exp_rd = model_read(rd_col, rd_row);
        @(posedge clk);
        #1;
        if (was_rd) check_eq("rd_data", rd_data, exp_rd);
    endtask

    task automatic make_layout(input int n, input int must_a, input int must_b);
        int placed, a;
        foreach (layout[i]) layout[i] = 1'b0;
        layout[must_a] = 1'b1;
        layout[must_b] = 1'b1;
        placed = 2;
        while (placed < n) begin
            a = $urandom_range(0, TILES - 1);
            if (!layout[a]) begin
                layout[a] = 1'b1;
                placed++;
            end
        end
    endtask

    function automatic int layout_ones();
        int s = 0;
        foreach (layout[i]) s += int'(layout[i]);
        return s;
    endfunction

    task automatic load_model();
        foreach (layout[i]) model_map[i] = layout[i];
        model_cnt   = layout_ones();
        model_valid = 1'b1;
    endtask

    // Random render request, never touching linear address `skip`.
    task automatic rand_read(input int skip);
        logic [5:0] c;
        logic [4:0] r;
        bit ok = 1'b0;
        while (!ok) begin
            c = ($urandom_range(0, 7) != 0) ? 6'($urandom_range(0, COLS - 1)) : 6'($urandom_range(0, 63));
            r = ($urandom_range(0, 7) != 0) ? 5'($urandom_range(0, ROWS - 1)) : 5'($urandom_range(0, 31));
            ok = (int'(c) >= COLS) || (int'(r) >= ROWS) || (int'(r) * COLS + int'(c) != skip);
        end
        rd_req = 1'b1;
        rd_col = c;
        rd_row = r;
    endtask

    // Pulse refill_start and wait for refill_done. From the pulse: one cycle
    // to latch pending, one IDLE cycle to dispatch, then 1200 writes, so done
    // is seen 1202 cycles later plus one per render cycle during the sweep.
    task automatic run_refill(input bit traffic, output int lat, output int nrd);
        refill_start = 1'b1;
        step();
        refill_start = 1'b0;
        lat = 1;
        nrd = 0;
        while (!refill_done && lat < 4000) begin
            if (traffic && lat >= 5 && lat < 1000 && $urandom_range(0, 3) == 0) begin
                rand_read(-1);
                nrd++;
            end else begin
                rd_req = 1'b0;
            end
            step();
            lat++;
        end
        rd_req = 1'b0;
        if (refill_done) load_model();
    endtask

    task automatic do_eat(input logic [5:0] c, input logic [4:0] r, input bit contend);
        int a, lat, stalls, exp_lat;
        bit inr, exp_hit;
        inr     = (int'(c) < COLS) && (int'(r) < ROWS);
        a       = inr ? int'(r) * COLS + int'(c) : -1;
        exp_hit = 1'b0;
        if (inr) exp_hit = model_map[a];
        exp_lat = inr ? 2 : 1;
        eat_req = 1'b1;
        eat_col = c;
        eat_row = r;
        lat     = 0;
        stalls  = 0;
        while (!eat_done && lat < 60) begin
            if (contend && lat < 20 && $urandom_range(0, 1) == 1) begin
                rand_read(a);
                stalls++;
            end else begin
                rd_req = 1'b0;
            end
            step();
            lat++;
        end
        eat_req = 1'b0;
        rd_req  = 1'b0;
        check_eq("eat_done_seen", eat_done, 1);
        if (stalls == 0) check_eq("eat_latency", lat, exp_lat);
        check_eq("eat_hit", eat_hit, int'(exp_hit));
        if (exp_hit) begin
            model_map[a] = 1'b0;
            model_cnt--;
        end
        step();
        check_eq("eat_done_one_cycle", eat_done, 0);
        check_eq("pellets_left", pellets_left, model_cnt);
    endtask

    function automatic int find_pellet(input int start, input int avoid);
        for (int k = 0; k < TILES; k++) begin
            if (model_map[(start + k) % TILES] && ((start + k) % TILES) != avoid)
                return (start + k) % TILES;
        end
        return -1;
    endfunction

    initial begin
        int lat, nrd, t, idx, pulses, first_done, second_done, lay_cnt;
        bit any_done;

        model_valid = 1'b0;
        model_cnt   = 0;
        foreach (model_map[i]) model_map[i] = 1'b0;

        // Reset values
        reset = 1'b1;
        step();
        step();
        check_eq("reset_rd_data", rd_data, 0);
        check_eq("reset_eat_done", eat_done, 0);
        check_eq("reset_eat_hit", eat_hit, 0);
        check_eq("reset_refill_done", refill_done, 0);
        check_eq("reset_pellets_left", pellets_left, 0);
        check_eq("reset_map_valid", map_valid, 0);
        check_eq("reset_layout_addr", layout_addr, 0);
        reset = 1'b0;
        step();

        // Reads before any refill return 0
        for (int k = 0; k < 4; k++) begin
            rand_read(-1);
            step();
        end
        rd_req = 1'b0;
        step();

        // First refill: 36 pellets, (3,2)=83 and (5,3)=125 included
        make_layout(36, 83, 125);
        run_refill(1'b0, lat, nrd);
        check_eq("refill1_latency", lat, 1202);
        check_eq("refill1_count", pellets_left, 36);
        check_eq("refill1_valid", map_valid, 1);
        step();
        check_eq("refill1_done_one_cycle", refill_done, 0);

        // Full render scan against the model
        for (int a = 0; a < TILES; a++) begin
            rd_req = 1'b1;
            rd_col = 6'(a % COLS);
            rd_row = 5'(a / COLS);
            step();
        end
        rd_req = 1'b0;
        step();

        // Eat (3,2) then re-eat it
        do_eat(6'd3, 5'd2, 1'b0);
        check_eq("eat32_count", pellets_left, 35);
        do_eat(6'd3, 5'd2, 1'b0);
        check_eq("reeat32_count", pellets_left, 35);

        // Eat stalled by continuous render traffic
        t = find_pellet(0, 125);
        eat_req  = 1'b1;
        eat_col  = 6'(t % COLS);
        eat_row  = 5'(t / COLS);
        any_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            rand_read(t);
            step();
            if (eat_done) any_done = 1'b1;
        end
        check_eq("stall_no_done", any_done, 0);
        rd_req = 1'b0;
        lat = 0;
        while (!eat_done && lat < 10) begin
            step();
            lat++;
        end
        check_eq("stall_release_latency", lat, 2);
        check_eq("stall_hit", eat_hit, 1);
        model_map[t] = 1'b0;
        model_cnt--;
        eat_req = 1'b0;
        step();
        check_eq("stall_count", pellets_left, model_cnt);
        rd_req = 1'b1;
        rd_col = 6'(t % COLS);
        rd_row = 5'(t / COLS);
        step();
        check_eq("stall_tile_cleared", rd_data, 0);
        rd_req = 1'b0;

        // Out-of-range eat: col 45 row 2 would alias tile (5,3) if mis-handled
        do_eat(6'd45, 5'd2, 1'b0);
        rd_req = 1'b1;
        rd_col = 6'd5;
        rd_row = 5'd3;
        step();
        check_eq("oor_alias_tile_intact", rd_data, 1);
        rd_col = 6'd3;
        rd_row = 5'd31;
        step();
        check_eq("oor_read_row31", rd_data, 0);
        rd_req = 1'b0;
        step();

        // Refill requested during EAT_CHK and again mid-sweep
        t = find_pellet(int'($urandom_range(0, TILES - 1)), -1);
        make_layout(200 + int'($urandom_range(0, 100)), 83, 125);
        lay_cnt = layout_ones();
        eat_req = 1'b1;
        eat_col = 6'(t % COLS);
        eat_row = 5'(t / COLS);
        step();
        refill_start = 1'b1;
        step();
        refill_start = 1'b0;
        check_eq("dbl_eat_done", eat_done, 1);
        check_eq("dbl_eat_hit", eat_hit, 1);
        model_map[t] = 1'b0;
        model_cnt--;
        eat_req     = 1'b0;
        idx         = 0;
        pulses      = 0;
        first_done  = -1;
        second_done = -1;
        while (idx < 2500) begin
            refill_start = (idx == 600);
            step();
            idx++;
            if (refill_done) begin
                pulses++;
                if (first_done < 0) first_done = idx;
                else if (second_done < 0) second_done = idx;
            end
        end
        refill_start = 1'b0;
        check_eq("dbl_pulses", pulses, 2);
        check_eq("dbl_first_done", first_done, 1202);
        check_eq("dbl_sweep_gap", second_done - first_done, 1201);
        if (pulses > 0) load_model();
        check_eq("dbl_count", pellets_left, lay_cnt);
        check_eq("dbl_valid", map_valid, 1);

        // Randomized eats with optional render contention
        for (int it = 0; it < 150; it++) begin
            logic [5:0] c;
            logic [4:0] r;
            int a, f;
            if ($urandom_range(0, 9) == 0) begin
                c = 6'($urandom_range(COLS, 63));
                r = 5'($urandom_range(0, 31));
            end else begin
                a = $urandom_range(0, TILES - 1);
                if ($urandom_range(0, 1) == 1) begin
                    f = find_pellet(a, -1);
                    if (f >= 0) a = f;
                end
                c = 6'(a % COLS);
                r = 5'(a / COLS);
            end
            do_eat(c, r, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) begin
                rand_read(-1);
                step();
            end
            rd_req = 1'b0;
        end

        // Reset in the middle of a sweep
        refill_start = 1'b1;
        step();
        refill_start = 1'b0;
        repeat (500) step();
        reset = 1'b1;
        step();
        model_valid = 1'b0;
        model_cnt   = 0;
        check_eq("midrst_eat_done", eat_done, 0);
        check_eq("midrst_refill_done", refill_done, 0);
        check_eq("midrst_pellets_left", pellets_left, 0);
        check_eq("midrst_map_valid", map_valid, 0);
        check_eq("midrst_layout_addr", layout_addr, 0);
        check_eq("midrst_rd_data", rd_data, 0);
        reset = 1'b0;
        step();
        for (int k = 0; k < 8; k++) begin
            rand_read(-1);
            step();
        end
        rd_req = 1'b0;
        step();
        run_refill(1'b1, lat, nrd);
        check_eq("refill3_latency", lat, 1202 + nrd);
        check_eq("refill3_count", pellets_left, model_cnt);
        check_eq("refill3_valid", map_valid, 1);
        for (int k = 0; k < 40; k++) begin
            rand_read(-1);
            step();
        end
        rd_req = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pellet_map_arbiter.md
# pellet_map_arbiter

Owns the 40x30 tile pellet bitmap and arbitrates its single access port between three clients: the VGA renderer (read-only, fixed latency), the scoring logic (atomic check-and-clear "eat"), and the level refill sweep. Sits between the scoring module, the pixel pipeline and the maze layout ROM. Maintains the live remaining-pellet count, which the game FSM uses for its win condition.

## Interface
- TILE_COLS, 40, tiles per row (16-px tiles, 640 px)
- TILE_ROWS, 30, tiles per column (480 px)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rd_req  in  1  renderer read strobe
- rd_col / rd_row  in  6 / 5  renderer tile coordinates
- rd_data  out  1  pellet bit, valid the cycle after rd_req
- eat_req  in  1  scoring eat request, level, held until eat_done
- eat_col / eat_row  in  6 / 5  tile to eat, stable while eat_req is high
- eat_done  out  1  one-cycle completion pulse
- eat_hit  out  1  valid with eat_done: 1 = a pellet was present and is now cleared
- refill_start  in  1  one-cycle pulse requesting a full bitmap reload
- layout_addr  out  11  linear tile address presented to the layout ROM
- layout_bit  in  1  combinational pellet bit for layout_addr
- refill_done  out  1  one-cycle pulse when the sweep completes
- pellets_left  out  11  remaining pellet count
- map_valid  out  1  high once the first refill has completed

## Operation
- Linear address = row*TILE_COLS + col. A coordinate with col ≥ TILE_COLS or row ≥ TILE_ROWS is out of range.
- Port: one access per cycle (read or write). Priority: render > refill > eat.
- Render: always granted. An out-of-range read, or a read while map_valid=0, returns 0. Data reflects all writes issued in earlier cycles.
- FSM states: IDLE, REFILL, EAT_CHK, DONE.
  - IDLE:
    - If refill is pending, go to REFILL.
    - Else if eat_req is high: an out-of-range request goes to DONE with hit=0 and makes no access. Otherwise, when the port is free, issue the read and go to EAT_CHK. When rd_req holds the port, stay in IDLE.
  - EAT_CHK: the latched bit is 0 → DONE, hit=0, no write. The bit is 1 → write 0 when the port is free (stall while rd_req), decrement pellets_left, then go to DONE with hit=1.
  - DONE: eat_done=1 for one cycle, then IDLE. eat_req is ignored in this cycle; the requester deasserts eat_req or presents a new request on the next cycle.
  - REFILL:
    - On entry, clear pellets_left and the pending flag, and set the address to 0.
    - Each free-port cycle writes layout_bit to the current address, adds layout_bit to pellets_left, and increments the address. Stall while rd_req.
    - After address NUM_TILES-1 is written: pulse refill_done, set map_valid, return to IDLE.
- refill_start sets a sticky pending flag in any state. A pulse that arrives during REFILL sets pending again, so a second sweep runs after the current one.
- An eat in progress always completes before a refill begins. Eats wait during a refill.
- pellets_left never wraps: a decrement happens only on a confirmed 1→0 write.

## Timing
- Reset values:
  - rd_data, eat_done, eat_hit, refill_done, pellets_left, map_valid, layout_addr: all 0.
  - FSM goes to IDLE and the pending flag is cleared.
  - Bitmap contents are undefined; they are masked by map_valid=0.
- Reset mid-operation abandons the eat or refill without a done pulse. A new refill is required.
- Render read latency is exactly 1 cycle, independent of FSM state.
- Eat with no render contention: accepted at cycle N, eat_done at N+2 for both hit and miss. An out-of-range eat gives eat_done at N+1.
- Refill with no contention: 1200 cycles from entering REFILL to refill_done. Each rd_req cycle adds one cycle.

## Structure
- Package pacman_pkg: TILE_COLS, TILE_ROWS, NUM_TILES=1200, tile_addr_t (11 bits), arbiter state enum.
- Sub-module pellet_tile_addr: combinational row*40+col plus range flag. Instantiated once for render and once for eat.
- Bitmap: 1200x1 storage with a registered read, inferred as a RAM.

## Test plan
- Refill with a layout that has exactly 36 ones, no render traffic → refill_done after 1200 cycles, pellets_left=36, map_valid=1.
- Eat tile (3,2) holding a pellet → eat_done at N+2 with hit=1, pellets_left=35. Re-eat the same tile → hit=0, count unchanged.
- rd_req held continuously during an eat → the eat stalls with no done pulse. Release rd_req → the eat completes and the next render read of that tile returns 0.
- Eat at col=45 → eat_done at N+1, hit=0, no bitmap change. Render read at row=31 → rd_data=0.
- refill_start pulsed during EAT_CHK, then again mid-REFILL → the eat finishes first, followed by two complete sweeps and two refill_done pulses.
- Reset asserted mid-refill → all outputs 0, and reads return 0 until a new refill completes.
